// File: rtl/sub_share_arbiter_if.sv
// Requester-side bus of the shared subtractor arbiter.
// Carries the per-requester request, mode and operand vectors toward the arbiter,
// and the acknowledge, result, borrow, busy and grant index back to the requesters.
// master: the game-logic requesters. slave: sub_share_arbiter.
interface sub_share_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned DW = 10;
    localparam int unsigned GW = 3;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    absmode;
    logic [NREQ*DW-1:0] a_in;
    logic [NREQ*DW-1:0] b_in;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      result;
    logic               borrow;
    logic               busy;
    logic [GW-1:0]      gnt_id;

    modport master (
        output req, absmode, a_in, b_in,
        input  ack, result, borrow, busy, gnt_id
    );

    modport slave (
        input  req, absmode, a_in, b_in,
        output ack, result, borrow, busy, gnt_id
    );
endinterface

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one 10-bit subtractor (D = A - B mod 1024)
// between NREQ requesters. An abs-mode request with A < B takes a second pass
// through the same subtractor with swapped operands.
// Ports:
//   clk     - system clock, rising edge
//   resetn  - asynchronous active-low reset
//   bus     - slave side of sub_share_arbiter_if (req/absmode/a_in/b_in in,
//             ack/result/borrow/busy/gnt_id out, all outputs registered)
module sub_share_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    sub_share_arbiter_if.slave    bus
);
    localparam int unsigned DW = 10;
    localparam int unsigned GW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SWAP = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_nx;
    logic [DW-1:0]   a_q, a_nx;
    logic [DW-1:0]   b_q, b_nx;
    logic            abs_q, abs_nx;
    logic [GW-1:0]   last_q, last_nx;
    logic [DW-1:0]   result_q, result_nx;
    logic            borrow_q, borrow_nx;
    logic [NREQ-1:0] ack_q, ack_nx;
    logic            busy_q, busy_nx;

    logic [DW-1:0]   sub_a_c, sub_b_c, sub_d_c;
    logic            a_lt_b_c;
    logic            win_found_c;
    logic [GW-1:0]   win_idx_c;
    logic [DW-1:0]   win_a_c, win_b_c;
    logic            win_abs_c;
    int unsigned     best_c;

    // Distance of requester idx from the round-robin start point (last+1).
    function automatic int unsigned rr_dist(input int unsigned idx, input logic [GW-1:0] last);
        return (idx + NREQ - 1 - 32'(last)) % NREQ;
    endfunction

    // Operand mux: the SWAP pass feeds B, A to the subtractor.
    always_comb begin : operand_mux
        sub_a_c = a_q;
        sub_b_c = b_q;
        if (state_q == SWAP) begin
            sub_a_c = b_q;
            sub_b_c = a_q;
        end
    end

    // The shared subtractor; wraps modulo 1024.
    assign sub_d_c  = sub_a_c - sub_b_c;
    assign a_lt_b_c = (a_q < b_q);

    // Round-robin winner: smallest distance from last grant + 1, with wrap.
    always_comb begin : rr_pick
        best_c    = NREQ;
        win_idx_c = last_q;
        win_a_c   = '0;
        win_b_c   = '0;
        win_abs_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (bus.req[i] && (rr_dist(i, last_q) < best_c)) begin
                best_c    = rr_dist(i, last_q);
                win_idx_c = GW'(i);
                win_a_c   = bus.a_in[i*DW +: DW];
                win_b_c   = bus.b_in[i*DW +: DW];
                win_abs_c = bus.absmode[i];
            end
        end
    end

    assign win_found_c = |bus.req;

    // Next state and next register values.
    always_comb begin : fsm_next
        state_nx  = state_q;
        a_nx      = a_q;
        b_nx      = b_q;
        abs_nx    = abs_q;
        last_nx   = last_q;
        result_nx = result_q;
        borrow_nx = borrow_q;
        ack_nx    = '0;

        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    a_nx     = win_a_c;
                    b_nx     = win_b_c;
                    abs_nx   = win_abs_c;
                    last_nx  = win_idx_c;
                    state_nx = CALC;
                end
            end
            CALC: begin
                result_nx = sub_d_c;
                borrow_nx = a_lt_b_c;
                state_nx  = (abs_q && a_lt_b_c) ? SWAP : RESP;
            end
            SWAP: begin
                result_nx = sub_d_c;
                borrow_nx = 1'b1;
                state_nx  = RESP;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Ack is registered, so it is raised on the edge that enters RESP.
        for (int unsigned i = 0; i < NREQ; i++) begin
            if ((state_nx == RESP) && (last_q == GW'(i))) begin
                ack_nx[i] = 1'b1;
            end
        end

        busy_nx = (state_nx != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin : regs
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            abs_q    <= 1'b0;
            last_q   <= GW'(NREQ - 1);
            result_q <= '0;
            borrow_q <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            a_q      <= a_nx;
            b_q      <= b_nx;
            abs_q    <= abs_nx;
            last_q   <= last_nx;
            result_q <= result_nx;
            borrow_q <= borrow_nx;
            ack_q    <= ack_nx;
            busy_q   <= busy_nx;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.result = result_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.gnt_id = last_q;
endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter: transaction-level model compared
// every cycle, plus hand-computed literal expectations for directed cases.
module tb_sub_share_arbiter;
    localparam int NREQ = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    sub_share_arbiter_if #(.NREQ(NREQ)) bus ();

    sub_share_arbiter #(.NREQ(NREQ)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: an operation granted at edge 0 acks at edge 1
    // (or 2 when a swap pass is needed) and the block is free one edge later.
    int        m_t    = -1;
    int        m_lat  = 0;
    int        m_last = NREQ - 1;
    int        m_id   = 0;
    int        m_a    = 0;
    int        m_b    = 0;
    bit        m_abs  = 1'b0;
    logic [NREQ-1:0] e_ack  = '0;
    int        e_res  = 0;
    int        e_bor  = 0;
    int        e_busy = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_t = -1; m_last = NREQ - 1;
            e_ack = '0; e_res = 0; e_bor = 0; e_busy = 0;
        end else if (m_t < 0) begin
            e_ack = '0;
            if (bus.req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int cand;
                    cand = (m_last + k) % NREQ;
                    if (m_t < 0 && bus.req[cand]) begin
                        m_id  = cand;
                        m_t   = 0;
                    end
                end
                m_last = m_id;
                m_a    = int'(bus.a_in[m_id*10 +: 10]);
                m_b    = int'(bus.b_in[m_id*10 +: 10]);
                m_abs  = bus.absmode[m_id];
                m_lat  = (m_abs && m_a < m_b) ? 2 : 1;
                e_busy = 1;
            end
        end else begin
            m_t++;
            if (m_t == 1) begin
                e_res = (m_a - m_b + 1024) % 1024;
                e_bor = (m_a < m_b) ? 1 : 0;
            end
            if (m_t == 2 && m_lat == 2) e_res = m_b - m_a;
            e_ack = '0;
            if (m_t == m_lat) e_ack[m_id] = 1'b1;
            if (m_t == m_lat + 1) begin
                e_busy = 0;
                m_t    = -1;
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        chk("ack",    int'(bus.ack),    int'(e_ack));
        chk("result", int'(bus.result), e_res);
        chk("borrow", int'(bus.borrow), e_bor);
        chk("busy",   int'(bus.busy),   e_busy);
        chk("gnt_id", int'(bus.gnt_id), m_last);
    end

    // One request/ack handshake with literal expectations.
    task automatic do_req(input int id, input int a, input int b, input bit ab,
                          input int exp_res, input int exp_bor, input int exp_lat);
        int start;
        bit got;
        @(posedge clk); #2;
        bus.a_in[id*10 +: 10] = 10'(a);
        bus.b_in[id*10 +: 10] = 10'(b);
        bus.absmode[id]       = ab;
        bus.req[id]           = 1'b1;
        start = cyc;
        got   = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.ack[id]) got = 1'b1;
        end
        if (!got) chk("ack_timeout", 0, 1);
        else begin
            chk("latency", cyc - start, exp_lat);
            chk("lit_result", int'(bus.result), exp_res);
            chk("lit_borrow", int'(bus.borrow), exp_bor);
        end
        @(posedge clk); #2;
        bus.req[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int exp_order[5];
        int first_res[2];
        int n_ack;
        int id;
        bit got;

        exp_order = '{0, 1, 2, 3, 0};
        bus.req = '0; bus.absmode = '0; bus.a_in = '0; bus.b_in = '0;

        // Reset and idle
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ack",    int'(bus.ack),    0);
        chk("rst_busy",   int'(bus.busy),   0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_gnt",    int'(bus.gnt_id), 3);
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_ack",  int'(bus.ack),  0);

        // Directed single requests
        do_req(0, 500, 123, 1'b0, 377, 0, 2);
        do_req(1, 3, 5, 1'b0, 1022, 1, 2);
        do_req(2, 3, 5, 1'b1, 2, 1, 3);
        do_req(2, 640, 640, 1'b1, 0, 0, 2);
        do_req(3, 1023, 0, 1'b1, 1023, 0, 2);

        // Contention: all four held high, new operands presented after each ack
        @(posedge clk); #2;
        bus.a_in    = {10'd1000, 10'd30, 10'd200, 10'd100};
        bus.b_in    = {10'd1,    10'd30, 10'd250, 10'd40};
        bus.absmode = 4'b0010;
        bus.req     = 4'b1111;
        n_ack = 0;
        first_res = '{0, 0};
        for (int n = 0; n < 80 && n_ack < 5; n++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                id = 0;
                for (int j = 0; j < NREQ; j++) if (bus.ack[j]) id = j;
                if (n_ack < 2) first_res[n_ack] = int'(bus.result);
                order[n_ack] = id;
                n_ack++;
                @(posedge clk); #2;
                if (n_ack == 5) bus.req = '0;
                else bus.a_in[id*10 +: 10] = bus.a_in[id*10 +: 10] + 10'd17;
            end
        end
        if (n_ack < 5) chk("contention_timeout", n_ack, 5);
        for (int k = 0; k < 5; k++) chk("grant_order", order[k], exp_order[k]);
        chk("contention_res0", first_res[0], 60);
        chk("contention_res1", first_res[1], 50);

        // Reset during CALC of requester 3
        repeat (3) @(posedge clk); #2;
        bus.a_in[30 +: 10] = 10'd100;
        bus.b_in[30 +: 10] = 10'd50;
        bus.absmode = '0;
        bus.req = 4'b1000;
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("abort_ack",    int'(bus.ack),    0);
        chk("abort_busy",   int'(bus.busy),   0);
        chk("abort_result", int'(bus.result), 0);
        chk("abort_gnt",    int'(bus.gnt_id), 3);
        repeat (2) @(posedge clk); #2;
        resetn = 1'b1;
        bus.a_in[0 +: 10] = 10'd20;
        bus.b_in[0 +: 10] = 10'd7;
        bus.req = 4'b1001;
        got = 1'b0;
        id  = -1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                got = 1'b1;
                for (int j = 0; j < NREQ; j++) if (bus.ack[j]) id = j;
                chk("post_reset_res", int'(bus.result), 13);
            end
        end
        chk("post_reset_winner", id, 0);
        @(posedge clk); #2;
        bus.req[0] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus.ack[3]) begin
                got = 1'b1;
                chk("req3_res", int'(bus.result), 50);
            end
        end
        if (!got) chk("req3_timeout", 0, 1);
        @(posedge clk); #2;
        bus.req = '0;
        repeat (4) @(posedge clk);
        #2;
        chk("end_busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
